// File: rtl/dual_lane_lsu_if.sv
// Issue, data-memory and writeback signals of the dual-lane load/store unit.
// The LSU takes the slave side; execute/memory/writeback logic takes the master side.
interface dual_lane_lsu_if #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32,
  parameter int TAG_W  = 5
);
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        a_sig;
  logic [1:0]        b_sig;
  logic [31:0]       a_addr;
  logic [31:0]       b_addr;
  logic [DATA_W-1:0] a_wdata;
  logic [DATA_W-1:0] b_wdata;
  logic [TAG_W-1:0]  a_tag;
  logic [TAG_W-1:0]  b_tag;

  logic [1:0]        dm_mem_sig;
  logic [ADDR_W-1:0] dm_address;
  logic [DATA_W-1:0] dm_input_data;
  logic [DATA_W-1:0] dm_data_out;

  logic              wb_valid;
  logic              wb_a_ld;
  logic              wb_b_ld;
  logic [DATA_W-1:0] wb_a_data;
  logic [DATA_W-1:0] wb_b_data;
  logic [TAG_W-1:0]  wb_a_tag;
  logic [TAG_W-1:0]  wb_b_tag;
  logic              wb_a_err;
  logic              wb_b_err;

  modport master (
    output in_valid, a_sig, b_sig, a_addr, b_addr, a_wdata, b_wdata, a_tag, b_tag,
    input  in_ready,
    input  dm_mem_sig, dm_address, dm_input_data,
    output dm_data_out,
    input  wb_valid, wb_a_ld, wb_b_ld, wb_a_data, wb_b_data, wb_a_tag, wb_b_tag,
    input  wb_a_err, wb_b_err
  );

  modport slave (
    input  in_valid, a_sig, b_sig, a_addr, b_addr, a_wdata, b_wdata, a_tag, b_tag,
    output in_ready,
    output dm_mem_sig, dm_address, dm_input_data,
    input  dm_data_out,
    output wb_valid, wb_a_ld, wb_b_ld, wb_a_data, wb_b_data, wb_a_tag, wb_b_tag,
    output wb_a_err, wb_b_err
  );
endinterface

// File: rtl/dual_lane_lsu.sv
// Dual-lane load/store unit: decodes an issue pair, serialises its memory ops onto the
// single data-memory port in program order and returns a lane-aligned result pair.
module dual_lane_lsu #(
  parameter int DEPTH  = 10000,
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32,
  parameter int TAG_W  = 5
) (
  input logic            clk,
  input logic            rst_n,
  dual_lane_lsu_if.slave bus
);

  localparam logic [1:0] SIG_NONE = 2'b00;
  localparam logic [1:0] SIG_RD   = 2'b01;
  localparam logic [1:0] SIG_WR   = 2'b10;
  localparam logic [1:0] SIG_ILL  = 2'b11;

  typedef enum logic [1:0] {
    S1_EMPTY  = 2'd0,
    S1_FIRST  = 2'd1,
    S1_SECOND = 2'd2
  } s1_state_e;

  typedef struct packed {
    logic [1:0]        op;
    logic              err;
    logic [ADDR_W-1:0] word;
    logic [DATA_W-1:0] wdata;
    logic [TAG_W-1:0]  tag;
  } lane_t;

  function automatic lane_t decode_lane(input logic [1:0]        sig,
                                        input logic [31:0]       addr,
                                        input logic [DATA_W-1:0] wdata,
                                        input logic [TAG_W-1:0]  tag);
    lane_t l;
    logic  range_err;
    l.word    = addr[ADDR_W+1:2];
    range_err = (addr[1:0] != 2'b00) || (addr[31:ADDR_W+2] != '0) ||
                ({{(32-ADDR_W){1'b0}}, l.word} >= 32'(DEPTH));
    l.err     = (sig == SIG_ILL) || ((sig != SIG_NONE) && range_err);
    l.op      = l.err ? SIG_NONE : sig;
    l.wdata   = wdata;
    l.tag     = tag;
    return l;
  endfunction

  s1_state_e         state_q, state_d;
  lane_t             a_q, b_q, sel;
  logic              two_ops, in_ready, accept;
  logic              issuing, issue_last, issue_b;
  logic [1:0]        dm_sig;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_data;

  logic              s2_vld_q, s2_last_q, s2_b_q;
  logic              s2_a_ld_q, s2_b_ld_q, s2_a_err_q, s2_b_err_q;
  logic [TAG_W-1:0]  s2_a_tag_q, s2_b_tag_q;
  logic [DATA_W-1:0] a_hold_q;
  logic              retire;

  logic              wb_vld_q, wb_a_ld_q, wb_b_ld_q, wb_a_err_q, wb_b_err_q;
  logic [TAG_W-1:0]  wb_a_tag_q, wb_b_tag_q;
  logic [DATA_W-1:0] wb_a_data_q, wb_b_data_q;

  assign two_ops  = (a_q.op != SIG_NONE) && (b_q.op != SIG_NONE);
  // A two-op pair holds S1 for a second issue cycle, so it blocks the next accept.
  assign in_ready = !((state_q == S1_FIRST) && two_ops);
  assign accept   = bus.in_valid && in_ready;

  // ---- S1: accept, decode and issue ----
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S1_EMPTY;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      a_q <= decode_lane(bus.a_sig, bus.a_addr, bus.a_wdata, bus.a_tag);
      b_q <= decode_lane(bus.b_sig, bus.b_addr, bus.b_wdata, bus.b_tag);
    end
  end

  always_comb begin
    state_d    = state_q;
    issuing    = 1'b0;
    issue_last = 1'b0;
    issue_b    = 1'b0;
    dm_sig     = SIG_NONE;
    dm_addr    = '0;
    dm_data    = '0;
    case (state_q)
      S1_EMPTY: begin
        if (accept) state_d = S1_FIRST;
      end
      S1_FIRST: begin
        issuing    = 1'b1;
        issue_b    = (a_q.op == SIG_NONE);
        issue_last = !two_ops;
        if (two_ops)     state_d = S1_SECOND;
        else if (accept) state_d = S1_FIRST;
        else             state_d = S1_EMPTY;
      end
      S1_SECOND: begin
        issuing    = 1'b1;
        issue_b    = 1'b1;
        issue_last = 1'b1;
        state_d    = accept ? S1_FIRST : S1_EMPTY;
      end
      default: state_d = S1_EMPTY;
    endcase
    sel = issue_b ? b_q : a_q;
    if (issuing && (sel.op != SIG_NONE)) begin
      dm_sig  = sel.op;
      dm_addr = sel.word;
      if (sel.op == SIG_WR) dm_data = sel.wdata;
    end
  end

  // ---- S2: track the op whose read data returns this cycle ----
  always_ff @(posedge clk) begin
    if (!rst_n) s2_vld_q <= 1'b0;
    else        s2_vld_q <= issuing;
  end

  always_ff @(posedge clk) begin
    if (issuing) begin
      s2_last_q  <= issue_last;
      s2_b_q     <= issue_b;
      s2_a_ld_q  <= (a_q.op == SIG_RD);
      s2_b_ld_q  <= (b_q.op == SIG_RD);
      s2_a_err_q <= a_q.err;
      s2_b_err_q <= b_q.err;
      s2_a_tag_q <= a_q.tag;
      s2_b_tag_q <= b_q.tag;
    end
    if (s2_vld_q && !s2_last_q) a_hold_q <= bus.dm_data_out;
  end

  assign retire = s2_vld_q && s2_last_q;

  // ---- WB: lane-aligned result pair ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wb_vld_q    <= 1'b0;
      wb_a_ld_q   <= 1'b0;
      wb_b_ld_q   <= 1'b0;
      wb_a_err_q  <= 1'b0;
      wb_b_err_q  <= 1'b0;
      wb_a_tag_q  <= '0;
      wb_b_tag_q  <= '0;
      wb_a_data_q <= '0;
      wb_b_data_q <= '0;
    end else begin
      wb_vld_q    <= retire;
      wb_a_ld_q   <= retire && s2_a_ld_q;
      wb_b_ld_q   <= retire && s2_b_ld_q;
      wb_a_err_q  <= retire && s2_a_err_q;
      wb_b_err_q  <= retire && s2_b_err_q;
      wb_a_tag_q  <= retire ? s2_a_tag_q : '0;
      wb_b_tag_q  <= retire ? s2_b_tag_q : '0;
      wb_a_data_q <= (retire && s2_a_ld_q) ? (s2_b_q ? a_hold_q : bus.dm_data_out) : '0;
      wb_b_data_q <= (retire && s2_b_ld_q) ? bus.dm_data_out : '0;
    end
  end

  assign bus.in_ready      = in_ready;
  assign bus.dm_mem_sig    = dm_sig;
  assign bus.dm_address    = dm_addr;
  assign bus.dm_input_data = dm_data;
  assign bus.wb_valid      = wb_vld_q;
  assign bus.wb_a_ld       = wb_a_ld_q;
  assign bus.wb_b_ld       = wb_b_ld_q;
  assign bus.wb_a_err      = wb_a_err_q;
  assign bus.wb_b_err      = wb_b_err_q;
  assign bus.wb_a_tag      = wb_a_tag_q;
  assign bus.wb_b_tag      = wb_b_tag_q;
  assign bus.wb_a_data     = wb_a_data_q;
  assign bus.wb_b_data     = wb_b_data_q;

endmodule

// File: tb/tb_dual_lane_lsu.sv
// Bench for dual_lane_lsu: directed scenarios plus randomized pairs scored against
// a word-array memory model that applies each accepted pair's ops in program order.
module tb_dual_lane_lsu;
  localparam int DEPTH = 10000;
  localparam logic [1:0] NONE = 2'b00, RD = 2'b01, WR = 2'b10, ILL = 2'b11;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dual_lane_lsu_if #(.ADDR_W(14), .DATA_W(32), .TAG_W(5)) bus();

  dual_lane_lsu #(.DEPTH(DEPTH), .ADDR_W(14), .DATA_W(32), .TAG_W(5)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // Data memory: registered read, write at end of the issue cycle.
  bit [31:0] mem [DEPTH];
  always @(posedge clk) begin
    if (bus.dm_mem_sig == RD)
      bus.dm_data_out <= (bus.dm_address < 14'(DEPTH)) ? mem[bus.dm_address] : 32'hBAD0BAD0;
    if (bus.dm_mem_sig == WR && bus.dm_address < 14'(DEPTH))
      mem[bus.dm_address] <= bus.dm_input_data;
  end

  typedef struct packed {
    logic        a_ld, b_ld, a_err, b_err;
    logic [4:0]  a_tag, b_tag;
    logic [31:0] a_data, b_data;
  } wb_t;

  bit [31:0] ref_mem [DEPTH];
  wb_t       exp_q[$];
  int        n_checks = 0;
  int        n_fail   = 0;
  bit        wb_seen;

  task automatic model_lane(input logic [1:0] sig, input logic [31:0] addr, input logic [31:0] wd,
                            output logic ld, output logic err, output logic [31:0] data);
    ld   = 1'b0;
    data = 32'h0;
    err  = (sig == ILL) || (sig != NONE && ((addr % 4) != 0 || addr >= 32'(DEPTH * 4)));
    if (!err && sig == WR) ref_mem[addr / 4] = wd;
    if (!err && sig == RD) begin
      ld   = 1'b1;
      data = ref_mem[addr / 4];
    end
  endtask

  task automatic model_accept();
    wb_t         e;
    logic        ald, aerr, bld, berr;
    logic [31:0] ad, bd;
    model_lane(bus.a_sig, bus.a_addr, bus.a_wdata, ald, aerr, ad);
    model_lane(bus.b_sig, bus.b_addr, bus.b_wdata, bld, berr, bd);
    e.a_ld = ald;  e.a_err = aerr; e.a_data = ad; e.a_tag = bus.a_tag;
    e.b_ld = bld;  e.b_err = berr; e.b_data = bd; e.b_tag = bus.b_tag;
    exp_q.push_back(e);
  endtask

  // One clock: record accepts, then at the falling edge score dm_* and any result pair.
  task automatic tick();
    bit  acc, rst_edge;
    wb_t got, e;
    acc      = bus.in_valid && bus.in_ready && rst_n;
    rst_edge = !rst_n;
    if (acc) model_accept();
    @(posedge clk);
    if (rst_edge) exp_q.delete();
    @(negedge clk);
    n_checks++;
    if (bus.dm_mem_sig == ILL ||
        (bus.dm_mem_sig == NONE && (bus.dm_address != 0 || bus.dm_input_data != 0))) begin
      n_fail++;
      $display("FAIL dm_clean: sig=%b addr=%0d data=%h, required sig!=11 and addr/data 0 when idle",
               bus.dm_mem_sig, bus.dm_address, bus.dm_input_data);
    end
    wb_seen = bus.wb_valid;
    if (bus.wb_valid) begin
      got.a_ld = bus.wb_a_ld;   got.b_ld = bus.wb_b_ld;
      got.a_err = bus.wb_a_err; got.b_err = bus.wb_b_err;
      got.a_tag = bus.wb_a_tag; got.b_tag = bus.wb_b_tag;
      got.a_data = bus.wb_a_data; got.b_data = bus.wb_b_data;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL wb_unexpected: got %h, required no result pair", got);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          n_fail++;
          $display("FAIL wb_pair: got %h, required %h", got, e);
        end
      end
    end
  endtask

  task automatic drive(input bit v,
                       input logic [1:0] as, input logic [31:0] aa, input logic [31:0] ad, input logic [4:0] at,
                       input logic [1:0] bs, input logic [31:0] ba, input logic [31:0] bd, input logic [4:0] bt);
    bus.in_valid = v;
    bus.a_sig = as; bus.a_addr = aa; bus.a_wdata = ad; bus.a_tag = at;
    bus.b_sig = bs; bus.b_addr = ba; bus.b_wdata = bd; bus.b_tag = bt;
  endtask

  task automatic idle();
    drive(1'b0, NONE, 0, 0, 0, NONE, 0, 0, 0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    tick();
    tick();
    rst_n = 1'b1;
    n_checks++;
    if (bus.dm_mem_sig !== NONE) begin n_fail++; $display("FAIL rst_dm_sig: got %b, required 00", bus.dm_mem_sig); end
    n_checks++;
    if (bus.wb_valid !== 1'b0) begin n_fail++; $display("FAIL rst_wb_valid: got %b, required 0", bus.wb_valid); end
    n_checks++;
    if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready: got %b, required 1", bus.in_ready); end
    n_checks++;
    if ({bus.wb_a_data, bus.wb_b_data, bus.wb_a_tag, bus.wb_b_tag} !== '0) begin
      n_fail++; $display("FAIL rst_wb_fields: got %h/%h, required 0", bus.wb_a_data, bus.wb_b_data);
    end
  endtask

  task automatic test_single_store();
    drive(1'b1, WR, 32'h10, 32'hDEADBEEF, 5'd1, NONE, 32'h0, 32'h0, 5'd2);
    n_checks++;
    if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL st_ready: got %b, required 1", bus.in_ready); end
    tick();
    idle();
    n_checks++;
    if ({bus.dm_mem_sig, bus.dm_address, bus.dm_input_data} !== {WR, 14'd4, 32'hDEADBEEF}) begin
      n_fail++; $display("FAIL st_issue: got sig=%b addr=%0d data=%h, required 10/4/deadbeef",
                         bus.dm_mem_sig, bus.dm_address, bus.dm_input_data);
    end
    tick();
    n_checks++;
    if (bus.dm_mem_sig !== NONE || wb_seen) begin
      n_fail++; $display("FAIL st_one_cycle: got sig=%b wb=%b, required 00/0", bus.dm_mem_sig, wb_seen);
    end
    tick();
    n_checks++;
    if (!wb_seen || bus.wb_a_ld !== 1'b0 || bus.wb_a_err !== 1'b0) begin
      n_fail++; $display("FAIL st_wb: got wb=%b ld=%b err=%b, required 1/0/0", wb_seen, bus.wb_a_ld, bus.wb_a_err);
    end
    tick();
    n_checks++;
    if (wb_seen) begin n_fail++; $display("FAIL st_wb_pulse: got wb=1 second cycle, required 0"); end
  endtask

  task automatic test_store_load_pair();
    drive(1'b1, WR, 32'h20, 32'h12345678, 5'd6, RD, 32'h20, 32'h0, 5'd7);
    tick();
    idle();
    n_checks++;
    if ({bus.in_ready, bus.dm_mem_sig, bus.dm_address} !== {1'b0, WR, 14'd8}) begin
      n_fail++; $display("FAIL sl_first: got ready=%b sig=%b addr=%0d, required 0/10/8",
                         bus.in_ready, bus.dm_mem_sig, bus.dm_address);
    end
    tick();
    n_checks++;
    if ({bus.in_ready, bus.dm_mem_sig, bus.dm_address} !== {1'b1, RD, 14'd8}) begin
      n_fail++; $display("FAIL sl_second: got ready=%b sig=%b addr=%0d, required 1/01/8",
                         bus.in_ready, bus.dm_mem_sig, bus.dm_address);
    end
    tick();
    n_checks++;
    if (wb_seen) begin n_fail++; $display("FAIL sl_early_wb: got wb=1 after E2, required 0"); end
    tick();
    n_checks++;
    if (!wb_seen || {bus.wb_b_ld, bus.wb_b_tag, bus.wb_b_data} !== {1'b1, 5'd7, 32'h12345678}) begin
      n_fail++; $display("FAIL sl_wb: got wb=%b ld=%b tag=%0d data=%h, required 1/1/7/12345678",
                         wb_seen, bus.wb_b_ld, bus.wb_b_tag, bus.wb_b_data);
    end
  endtask

  task automatic test_back_to_back();
    int          hits[$];
    logic [31:0] data[$];
    drive(1'b1, WR, 32'h14, 32'hA5A50014, 5'd0, WR, 32'h18, 32'h5A5A0018, 5'd0);
    tick();
    idle();
    repeat (4) tick();
    for (int i = 0; i < 8; i++) begin
      if (i < 3) begin
        drive(1'b1, RD, 32'h10 + 32'(4 * i), 32'h0, 5'(10 + i), NONE, 32'h0, 32'h0, 5'd0);
        n_checks++;
        if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready: got 0 at pair %0d, required 1", i); end
      end else begin
        idle();
      end
      tick();
      if (wb_seen) begin
        hits.push_back(i);
        data.push_back(bus.wb_a_data);
      end
    end
    n_checks++;
    if (hits.size() != 3 || hits[0] != 2 || hits[1] != 3 || hits[2] != 4) begin
      n_fail++; $display("FAIL b2b_timing: got %0d results first at %0d, required 3 at cycles 2,3,4",
                         hits.size(), (hits.size() > 0) ? hits[0] : -1);
    end else begin
      n_checks++;
      if (data[0] !== 32'hDEADBEEF || data[1] !== 32'hA5A50014 || data[2] !== 32'h5A5A0018) begin
        n_fail++; $display("FAIL b2b_data: got %h %h %h, required deadbeef a5a50014 5a5a0018",
                           data[0], data[1], data[2]);
      end
    end
  endtask

  task automatic test_errors();
    drive(1'b1, RD, 32'h13, 32'h0, 5'd3, RD, 32'h9C40, 32'h0, 5'd4);
    tick();
    idle();
    n_checks++;
    if (bus.dm_mem_sig !== NONE) begin n_fail++; $display("FAIL err_no_access: got sig=%b, required 00", bus.dm_mem_sig); end
    tick();
    tick();
    n_checks++;
    if (!wb_seen || {bus.wb_a_err, bus.wb_b_err, bus.wb_a_ld, bus.wb_b_ld} !== 4'b1100 ||
        bus.wb_a_data !== 32'h0 || bus.wb_b_data !== 32'h0) begin
      n_fail++; $display("FAIL err_both: got wb=%b err=%b%b ld=%b%b data=%h/%h, required 1/11/00/0/0", wb_seen,
                         bus.wb_a_err, bus.wb_b_err, bus.wb_a_ld, bus.wb_b_ld, bus.wb_a_data, bus.wb_b_data);
    end
    drive(1'b1, ILL, 32'h10, 32'h0, 5'd5, RD, 32'h10, 32'h0, 5'd6);
    tick();
    idle();
    tick();
    tick();
    n_checks++;
    if (!wb_seen || bus.wb_a_err !== 1'b1 || bus.wb_b_err !== 1'b0 || bus.wb_b_data !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL err_illegal: got wb=%b a_err=%b b_err=%b b_data=%h, required 1/1/0/deadbeef",
                         wb_seen, bus.wb_a_err, bus.wb_b_err, bus.wb_b_data);
    end
    drive(1'b1, RD, 32'h0001_0010, 32'h0, 5'd8, WR, 32'h9C3C, 32'hCAFEF00D, 5'd9);
    tick();
    idle();
    tick();
    tick();
    n_checks++;
    if (!wb_seen || bus.wb_a_err !== 1'b1 || bus.wb_b_err !== 1'b0) begin
      n_fail++; $display("FAIL err_high_addr: got wb=%b a_err=%b b_err=%b, required 1/1/0",
                         wb_seen, bus.wb_a_err, bus.wb_b_err);
    end
  endtask

  task automatic test_reset_mid();
    int wb_cnt;
    drive(1'b1, RD, 32'h18, 32'h0, 5'd3, RD, 32'h14, 32'h0, 5'd4);
    tick();
    idle();
    tick();
    n_checks++;
    if ({bus.dm_mem_sig, bus.dm_address} !== {RD, 14'd5}) begin
      n_fail++; $display("FAIL rm_second: got sig=%b addr=%0d, required 01/5", bus.dm_mem_sig, bus.dm_address);
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n_checks++;
    if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL rm_ready: got %b, required 1", bus.in_ready); end
    wb_cnt = 0;
    repeat (3) begin
      tick();
      if (wb_seen) wb_cnt++;
    end
    n_checks++;
    if (wb_cnt != 0) begin n_fail++; $display("FAIL rm_no_wb: got %0d results, required 0", wb_cnt); end
    drive(1'b1, RD, 32'h10, 32'h0, 5'd11, NONE, 32'h0, 32'h0, 5'd0);
    tick();
    idle();
    tick();
    tick();
    n_checks++;
    if (!wb_seen || bus.wb_a_data !== 32'hDEADBEEF || bus.wb_a_ld !== 1'b1) begin
      n_fail++; $display("FAIL rm_reload: got wb=%b ld=%b data=%h, required 1/1/deadbeef",
                         wb_seen, bus.wb_a_ld, bus.wb_a_data);
    end
  endtask

  function automatic logic [1:0] rand_sig();
    int r;
    r = $urandom_range(0, 9);
    if (r < 2) return NONE;
    if (r < 5) return RD;
    if (r < 8) return WR;
    if (r < 9) return ILL;
    return RD;
  endfunction

  function automatic logic [31:0] rand_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r < 7)  return 32'($urandom_range(0, 31)) * 4;
    if (r == 7) return 32'($urandom_range(0, 127)) | 32'h1;
    if (r == 8) return (32'd9995 + 32'($urandom_range(0, 9))) * 4;
    return 32'h0001_0000 + 32'($urandom_range(0, 15)) * 4;
  endfunction

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 3) != 0,
            rand_sig(), rand_addr(), $urandom, 5'($urandom_range(0, 31)),
            rand_sig(), rand_addr(), $urandom, 5'($urandom_range(0, 31)));
      tick();
    end
    idle();
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) tick();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL rand_drain: got %0d pairs outstanding, required 0", exp_q.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "timeout");
  end

  initial begin
    idle();
    test_reset();
    test_single_store();
    test_store_load_pair();
    test_back_to_back();
    test_errors();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dual_lane_lsu.md
Name: dual_lane_lsu

Overview:
- Load/store unit directly upstream of the single-ported 32-bit data memory (10000 words, 1-cycle registered read, mem_sig 00 none / 01 read / 10 write).
- Accepts an issue pair (lane A older than lane B) from the execute stage and converts byte addresses to word addresses.
- Serialises up to two memory ops onto the one memory port, in program order.
- Returns load results to writeback as a lane-aligned pair.

Parameters:
- DEPTH, 10000, number of data-memory words; word index ≥ DEPTH is out of range.
- ADDR_W, 14, data-memory word-address width.
- DATA_W, 32, data width.
- TAG_W, 5, destination-register tag width.

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  issue pair valid
- in_ready  out  1  LSU can accept a pair this cycle
- a_sig, b_sig  in  2 each  per-lane memory op (00 none, 01 read, 10 write, 11 illegal)
- a_addr, b_addr  in  32 each  per-lane byte address
- a_wdata, b_wdata  in  DATA_W each  per-lane store data
- a_tag, b_tag  in  TAG_W each  per-lane destination tag
- dm_mem_sig  out  2  to data memory mem_sig
- dm_address  out  ADDR_W  to data memory address
- dm_input_data  out  DATA_W  to data memory write data
- dm_data_out  in  DATA_W  from data memory read data
- wb_valid  out  1  result pair valid (one cycle)
- wb_a_ld, wb_b_ld  out  1 each  lane result carries load data
- wb_a_data, wb_b_data  out  DATA_W each  load data, 0 if not a load
- wb_a_tag, wb_b_tag  out  TAG_W each  tags passed through
- wb_a_err, wb_b_err  out  1 each  lane op was suppressed (misaligned / out of range / illegal)

Behaviour:
- Reset (rst_n=0 at an edge): FSM to S1_EMPTY, S2 invalid. Outputs: dm_mem_sig=00, dm_address=0, dm_input_data=0, all wb_* = 0, in_ready=1 from the cycle after reset.
- Accept: in_valid && in_ready at edge E0 latches the pair into S1. Each lane is decoded at accept:
  - word = addr[ADDR_W+1:2].
  - err = (sig==11) || (sig!=00 && (addr[1:0]!=0 || addr[31:ADDR_W+2]!=0 || word>=DEPTH)).
  - Effective op = none when err=1.
- S1 FSM, drives dm_* combinationally from registered state:
  - S1_EMPTY: dm_mem_sig=00.
  - S1_FIRST: drive the first effective op (A if A has one, else B).
  - S1_SECOND: drive B's op.
  - Transitions:
    - Pair with ≤1 effective op: S1_FIRST for one cycle, then to S1_FIRST (new accept) or S1_EMPTY.
    - Pair with 2 effective ops: S1_FIRST → S1_SECOND → next.
  - in_ready = 0 only while S1 is in S1_FIRST holding a two-op pair. Sustained throughput is 1 pair/cycle with ≤1 op per pair, 1 pair per 2 cycles otherwise.
- Data memory samples dm_* at the end of each S1 issue cycle; dm_data_out is valid the following cycle.
- S2 captures dm_data_out into the issuing lane's data register at the edge after the read is valid.
  - For a two-load pair, A's data is held while B completes.
  - The pair then moves to the writeback registers.
- wb_valid pulses 1 cycle:
  - For ≤1 op: after edge E2, i.e. visible in the cycle after E2.
  - For 2 ops: after E3.
- Ordering:
  - Pairs retire in accept order, never reordered.
  - A is always issued before B, so a B load after an A store to the same word returns the stored data.
  - The next pair likewise sees all prior stores.
- dm_mem_sig is never 11. dm_address and dm_input_data are 0 whenever dm_mem_sig=00.
- Errored lane: wb_x_err=1, wb_x_ld=0, data 0, no memory access. The other lane proceeds normally.
- in_valid=0 pairs create bubbles only; wb_valid=0 for bubbles.
- Reset mid-operation discards S1/S2 contents. An op issued in that cycle may complete in memory, but produces no wb_valid.

Test Plan:
- Reset → dm_mem_sig=00, wb_valid=0, in_ready=1. Pair A=write 0x10 data 0xDEADBEEF, B=none → dm_address=4, dm_mem_sig=10 one cycle; wb_valid with wb_a_ld=0, err=0.
- Pair A=write 0x20 data 0x12345678, B=read 0x20 tag 7 → in_ready low 1 cycle, issues 10 then 01 at address 8; wb_valid after E3 with wb_b_data=0x12345678, wb_b_tag=7, wb_b_ld=1.
- Back-to-back single-load pairs (reads of 0x10, 0x14, 0x18 over 3 cycles) → in_ready stays 1; wb_valid on 3 consecutive cycles with data in order.
- A=read 0x13 (misaligned), B=read 0x9C40 (word 10000) → no memory access; wb_a_err=1, wb_b_err=1, data 0. Also A sig=11 → err=1.
- Reset asserted during S1_SECOND of a two-load pair → no wb_valid. After release, in_ready=1 and a new read of 0x10 returns 0xDEADBEEF.
